lsu_mem_master: RTL

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request at a time, single-word bus.
// Sub-word stores are done as read-modify-write; loads are extended to 32 bits.
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  we_q;
    logic                  uns_q;
    logic                  err_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    // Holds store data until the merge, then the outgoing word or load result.
    logic [DATA_WIDTH-1:0] data_q;

    logic                  accept;
    logic                  req_err;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = req_valid && (state == IDLE);

    // Classify illegal size or misaligned address at request time.
    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = req_addr[0];
            SZ_W:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Pick the addressed lane, extend it, and build the merged store word.
    always_comb begin
        lane_b = 8'h00;
        unique case (addr_q[1:0])
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            2'd3: lane_b = mem_rdata[31:24];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_ext = mem_rdata;
        if (size_q == SZ_B)
            load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
        else if (size_q == SZ_H)
            load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};

        merged = mem_rdata;
        if (size_q == SZ_B) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged = {data_q[15:0], mem_rdata[15:0]};
        end else begin
            merged = {mem_rdata[31:16], data_q[15:0]};
        end
    end

    // Sequence each request through read, capture, write and response.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = RESP;
                    else if (req_we && req_size == SZ_W)
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latch the request on accept, then replace data with the read result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            size_q <= 2'b00;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            err_q  <= req_err;
            size_q <= req_size;
            addr_q <= req_addr;
            data_q <= req_err ? '0 : req_wdata;
        end else if (state == CAP) begin
            data_q <= we_q ? merged : load_ext;
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : '0;
    assign mem_read   = (state == RD);
    assign mem_write  = (state == WR);
    assign mem_addr   = (mem_read || mem_write)
                      ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_write ? data_q : '0;

endmodule
